// File: rtl/game_pkg.sv
// Shared definitions for the player/bullet subsystem: fire FSM states and
// screen coordinate widths.
package game_pkg;

    // Screen coordinate widths
    localparam int COL_W = 12;
    localparam int ROW_W = 11;

    // Signed width used for horizontal saturation so a step past either
    // edge never wraps before it is clamped
    localparam int SAT_W = 13;

    // Fire controller states
    typedef enum logic [1:0] {
        READY    = 2'd0,
        PULSE    = 2'd1,
        COOLDOWN = 2'd2,
        RELOAD   = 2'd3
    } fire_state_t;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a level debouncer. The debounced level
// only follows the synchronised input after it has disagreed for
// DEBOUNCE_CYCLES consecutive clocks; any return to agreement restarts the count.
module button_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Count consecutive clocks of disagreement; flip the level on the last one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_p1 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync_p1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ship_fire_ctrl.sv
// Player ship controller: debounced buttons drive the ship column and an
// active-low fire strobe with per-shot cooldown and a reloading magazine.
// Ship position is frozen while the strobe is low so the bullet manager
// latches a stable origin.
// Build option: define SHIP_AUTOFIRE_EN to let a held fire button keep
// requesting shots in READY; otherwise each shot needs a fresh press.
module ship_fire_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIRE_LOW_CYCLES = 32,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int MAG_SIZE        = 6,
    parameter int RELOAD_FRAMES   = 60,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 1888,
    parameter int X_START         = 944,
    parameter int Y_FIXED         = 1000,
    parameter int STEP            = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_fire,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             frame_tick,
    output logic             fire,
    output logic [COL_W-1:0] x_axis,
    output logic [ROW_W-1:0] y_axis,
    output logic [3:0]       ammo,
    output logic             reloading
);

    localparam int PULSE_W   = $clog2(FIRE_LOW_CYCLES + 1);
    localparam int FRAME_MAX = (COOLDOWN_FRAMES > RELOAD_FRAMES) ? COOLDOWN_FRAMES : RELOAD_FRAMES;
    localparam int FRAME_W   = $clog2(FRAME_MAX + 1);

    localparam logic [PULSE_W-1:0] PULSE_LAST  = PULSE_W'(FIRE_LOW_CYCLES - 1);
    localparam logic [FRAME_W-1:0] COOL_LAST   = FRAME_W'(COOLDOWN_FRAMES - 1);
    localparam logic [FRAME_W-1:0] RELOAD_LAST = FRAME_W'(RELOAD_FRAMES - 1);
    localparam logic [3:0]         MAG_FULL    = 4'(MAG_SIZE);

    localparam logic signed [SAT_W-1:0] STEP_S  = SAT_W'(STEP);
    localparam logic signed [SAT_W-1:0] X_MIN_S = SAT_W'(X_MIN);
    localparam logic signed [SAT_W-1:0] X_MAX_S = SAT_W'(X_MAX);
    localparam logic        [COL_W-1:0] X_RST   = COL_W'(X_START);

    fire_state_t          state;
    logic [PULSE_W-1:0]   pulse_cnt;
    logic [FRAME_W-1:0]   frame_cnt;
    logic                 fire_lvl;
    logic                 left_lvl;
    logic                 right_lvl;
    logic                 shot_req;
    logic                 shot_start;

    // One step left or right with clamping to the playfield edges
    function automatic logic [COL_W-1:0] move_x(input logic [COL_W-1:0] cur,
                                                input logic left,
                                                input logic right);
        logic signed [SAT_W-1:0] nxt;
        nxt = $signed({1'b0, cur});
        if (left && !right)
            nxt = nxt - STEP_S;
        else if (right && !left)
            nxt = nxt + STEP_S;
        if (nxt < X_MIN_S)
            nxt = X_MIN_S;
        else if (nxt > X_MAX_S)
            nxt = X_MAX_S;
        return nxt[COL_W-1:0];
    endfunction

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fire (
        .clock (clock),
        .reset (reset),
        .raw   (btn_fire),
        .level (fire_lvl)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clock (clock),
        .reset (reset),
        .raw   (btn_left),
        .level (left_lvl)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clock (clock),
        .reset (reset),
        .raw   (btn_right),
        .level (right_lvl)
    );

`ifdef SHIP_AUTOFIRE_EN
    // A held button keeps requesting; READY gating spaces the shots out
    assign shot_req = fire_lvl;
`else
    logic fire_lvl_q;

    // Previous debounced fire level for rising-edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            fire_lvl_q <= 1'b0;
        else
            fire_lvl_q <= fire_lvl;
    end

    assign shot_req = fire_lvl & ~fire_lvl_q;
`endif

    // Empty magazine never reaches READY; the ammo test is belt and braces
    assign shot_start = (state == READY) && shot_req && (ammo != 4'd0);

    assign y_axis = ROW_W'(Y_FIXED);

    // Shot sequencing: strobe width, cooldown and magazine reload
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= READY;
            fire      <= 1'b1;
            ammo      <= MAG_FULL;
            reloading <= 1'b0;
            pulse_cnt <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                READY: begin
                    if (shot_start) begin
                        state     <= PULSE;
                        fire      <= 1'b0;
                        ammo      <= ammo - 4'd1;
                        pulse_cnt <= '0;
                    end
                end
                PULSE: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        fire      <= 1'b1;
                        pulse_cnt <= '0;
                        frame_cnt <= '0;
                        if (ammo == 4'd0) begin
                            state     <= RELOAD;
                            reloading <= 1'b1;
                        end else begin
                            state <= COOLDOWN;
                        end
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (frame_tick) begin
                        if (frame_cnt == COOL_LAST) begin
                            state     <= READY;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                RELOAD: begin
                    if (frame_tick) begin
                        if (frame_cnt == RELOAD_LAST) begin
                            state     <= READY;
                            frame_cnt <= '0;
                            ammo      <= MAG_FULL;
                            reloading <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: state <= READY;
            endcase
        end
    end

    // Ship movement per frame; held still on the clock a shot starts and for
    // the whole strobe so the latched origin equals the pre-shot column
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            x_axis <= X_RST;
        else if (frame_tick && (state != PULSE) && !shot_start)
            x_axis <= move_x(x_axis, left_lvl, right_lvl);
    end

endmodule
